// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU request arbiter.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;

   localparam logic [1:0] MUX2_RS2 = 2'b00;
   localparam logic [1:0] MUX2_IMM = 2'b10;

   // Second ALU operand comes from the immediate only for OP-IMM instructions.
   function automatic logic [1:0] mux2_for(input logic [6:0] opcode);
      return (opcode == OPCODE_OP_IMM) ? MUX2_IMM : MUX2_RS2;
   endfunction

endpackage

// File: rtl/alu_rr_arbiter2.sv
// Two-way round-robin grant; the priority pointer is owned by the caller.
module alu_rr_arbiter2 (
   input  logic [1:0] req_valid_i,
   input  logic       rr_ptr_i,
   output logic [1:0] grant_o,
   output logic       grant_idx_o
);

   // A lone requester always wins; on contention the pointer decides.
   always_comb begin
      grant_o     = 2'b00;
      grant_idx_o = 1'b0;
      unique case (req_valid_i)
         2'b01: begin
            grant_o     = 2'b01;
            grant_idx_o = 1'b0;
         end
         2'b10: begin
            grant_o     = 2'b10;
            grant_idx_o = 1'b1;
         end
         2'b11: begin
            grant_o     = rr_ptr_i ? 2'b10 : 2'b01;
            grant_idx_o = rr_ptr_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_request_arbiter.sv
// Shares one combinational ALU between two requesters with a tagged response channel.
module alu_request_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [13:0] req_opcode,
   input  logic [5:0]  req_funct3,
   input  logic [13:0] req_funct7,
   input  logic [63:0] req_operand_a,
   input  logic [63:0] req_operand_b,
   output logic [6:0]  alu_opcode,
   output logic [2:0]  alu_funct3,
   output logic [6:0]  alu_funct7,
   output logic [4:0]  alu_FLEN,
   output logic        alu_mux1_select,
   output logic [1:0]  alu_mux2_select,
   output logic [31:0] alu_bus_rs1,
   output logic [31:0] alu_bus_rs2,
   output logic [31:0] alu_immediate,
   output logic [31:0] alu_Forward_rs1,
   output logic [31:0] alu_Forward_rs2,
   input  logic [31:0] alu_result,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [31:0] resp_data
);

   localparam int unsigned CntW =
      ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

   state_e            state_q;
   logic              rr_ptr_q;
   logic [CntW-1:0]   cnt_q;
   logic [6:0]        opcode_q;
   logic [2:0]        funct3_q;
   logic [6:0]        funct7_q;
   logic [31:0]       rs1_q;
   logic [31:0]       rs2_q;
   logic [1:0]        mux2_q;
   logic              resp_valid_q;
   logic              resp_id_q;
   logic [31:0]       resp_data_q;

   logic [1:0]        grant;
   logic              grant_idx;
   logic [6:0]        sel_opcode;
   logic [2:0]        sel_funct3;
   logic [6:0]        sel_funct7;
   logic [31:0]       sel_a;
   logic [31:0]       sel_b;

   alu_rr_arbiter2 u_rr_arbiter2 (
      .req_valid_i (req_valid),
      .rr_ptr_i    (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   // Grants are only offered while idle, so accept == any valid request in IDLE.
   assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;

   // Pick the granted requester's fields out of the packed request buses.
   always_comb begin
      sel_opcode = grant_idx ? req_opcode[13:7]     : req_opcode[6:0];
      sel_funct3 = grant_idx ? req_funct3[5:3]      : req_funct3[2:0];
      sel_funct7 = grant_idx ? req_funct7[13:7]     : req_funct7[6:0];
      sel_a      = grant_idx ? req_operand_a[63:32] : req_operand_a[31:0];
      sel_b      = grant_idx ? req_operand_b[63:32] : req_operand_b[31:0];
   end

   // Control FSM: latch an operation, hold the ALU inputs, capture and hold the result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= 1'b0;
         cnt_q        <= '0;
         opcode_q     <= '0;
         funct3_q     <= '0;
         funct7_q     <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         mux2_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (|grant) begin
                  opcode_q  <= sel_opcode;
                  funct3_q  <= sel_funct3;
                  funct7_q  <= sel_funct7;
                  rs1_q     <= sel_a;
                  rs2_q     <= sel_b;
                  mux2_q    <= mux2_for(sel_opcode);
                  resp_id_q <= grant_idx;
                  rr_ptr_q  <= ~grant_idx;
                  cnt_q     <= CntLoad;
                  state_q   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (cnt_q == '0) begin
                  resp_data_q  <= alu_result;
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            ST_RESP: begin
               // The exit edge deliberately does not look at new requests.
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign alu_opcode      = opcode_q;
   assign alu_funct3      = funct3_q;
   assign alu_funct7      = funct7_q;
   assign alu_FLEN        = 5'd0;
   assign alu_mux1_select = 1'b0;
   assign alu_mux2_select = mux2_q;
   assign alu_bus_rs1     = rs1_q;
   assign alu_bus_rs2     = rs2_q;
   assign alu_immediate   = rs2_q;
   assign alu_Forward_rs1 = 32'd0;
   assign alu_Forward_rs2 = 32'd0;
   assign resp_valid      = resp_valid_q;
   assign resp_id         = resp_id_q;
   assign resp_data       = resp_data_q;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Self-checking bench for alu_request_arbiter (WAIT_CYCLES=1 and WAIT_CYCLES=3 instances).
module tb_alu_request_arbiter;

   localparam int         W1  = 1;
   localparam logic [6:0] OPI = 7'b0010011;
   localparam logic [6:0] OPR = 7'b0110011;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Shared request fields; each instance has its own valid/ready handshake.
   logic [1:0]  req_valid;
   logic [13:0] req_opcode;
   logic [5:0]  req_funct3;
   logic [13:0] req_funct7;
   logic [63:0] req_operand_a;
   logic [63:0] req_operand_b;
   logic        resp_ready;

   logic [1:0]  req_ready;
   logic [6:0]  alu_opcode, alu_funct7;
   logic [2:0]  alu_funct3;
   logic [4:0]  alu_FLEN;
   logic        alu_mux1_select;
   logic [1:0]  alu_mux2_select;
   logic [31:0] alu_bus_rs1, alu_bus_rs2, alu_immediate, alu_Forward_rs1, alu_Forward_rs2;
   logic [31:0] alu_result;
   logic        resp_valid, resp_id;
   logic [31:0] resp_data;

   logic [1:0]  v3;
   logic        rr3;
   logic [1:0]  rdy3;
   logic [6:0]  a3_opcode, a3_funct7;
   logic [2:0]  a3_funct3;
   logic [4:0]  a3_flen;
   logic        a3_mux1;
   logic [1:0]  a3_mux2;
   logic [31:0] a3_rs1, a3_rs2, a3_imm, a3_f1, a3_f2, a3_result, d3;
   logic        rv3, id3;

   // Reference RV32 integer ALU.
   function automatic logic [31:0] alu_ref(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] a,
                                           input logic [31:0] b);
      case (f3)
         3'b000:  return (opc == OPR && f7[5]) ? a - b : a + b;
         3'b001:  return a << b[4:0];
         3'b100:  return a ^ b;
         3'b101:  return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  return a | b;
         3'b111:  return a & b;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_result = alu_ref(alu_opcode, alu_funct3, alu_funct7, alu_bus_rs1,
                               (alu_mux2_select == 2'b10) ? alu_immediate : alu_bus_rs2);
   assign a3_result  = alu_ref(a3_opcode, a3_funct3, a3_funct7, a3_rs1,
                               (a3_mux2 == 2'b10) ? a3_imm : a3_rs2);

   alu_request_arbiter #(.WAIT_CYCLES(1)) u_dut (
      .clk (clk), .reset (reset),
      .req_valid (req_valid), .req_ready (req_ready),
      .req_opcode (req_opcode), .req_funct3 (req_funct3), .req_funct7 (req_funct7),
      .req_operand_a (req_operand_a), .req_operand_b (req_operand_b),
      .alu_opcode (alu_opcode), .alu_funct3 (alu_funct3), .alu_funct7 (alu_funct7),
      .alu_FLEN (alu_FLEN), .alu_mux1_select (alu_mux1_select),
      .alu_mux2_select (alu_mux2_select), .alu_bus_rs1 (alu_bus_rs1),
      .alu_bus_rs2 (alu_bus_rs2), .alu_immediate (alu_immediate),
      .alu_Forward_rs1 (alu_Forward_rs1), .alu_Forward_rs2 (alu_Forward_rs2),
      .alu_result (alu_result), .resp_valid (resp_valid), .resp_ready (resp_ready),
      .resp_id (resp_id), .resp_data (resp_data)
   );

   alu_request_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
      .clk (clk), .reset (reset),
      .req_valid (v3), .req_ready (rdy3),
      .req_opcode (req_opcode), .req_funct3 (req_funct3), .req_funct7 (req_funct7),
      .req_operand_a (req_operand_a), .req_operand_b (req_operand_b),
      .alu_opcode (a3_opcode), .alu_funct3 (a3_funct3), .alu_funct7 (a3_funct7),
      .alu_FLEN (a3_flen), .alu_mux1_select (a3_mux1),
      .alu_mux2_select (a3_mux2), .alu_bus_rs1 (a3_rs1),
      .alu_bus_rs2 (a3_rs2), .alu_immediate (a3_imm),
      .alu_Forward_rs1 (a3_f1), .alu_Forward_rs2 (a3_f2),
      .alu_result (a3_result), .resp_valid (rv3), .resp_ready (rr3),
      .resp_id (id3), .resp_data (d3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_bound(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   function automatic logic pick(input logic [1:0] v, input logic pref);
      if (v == 2'b01) return 1'b0;
      if (v == 2'b10) return 1'b1;
      return pref;
   endfunction

   // ---------------- timeline model of the WAIT_CYCLES=1 instance ----------------
   // An accepted transaction is outstanding until its response is taken; its
   // response becomes visible W1 edges after the accepting edge.
   logic        m_busy, m_rr, m_rid, m_g;
   int          m_k, m_gi;
   logic [31:0] m_data, m_rdata, m_a, m_b;
   logic [6:0]  m_opc, m_f7;
   logic [2:0]  m_f3;
   logic [1:0]  m_mux, e_rdy;

   always @(negedge clk) begin
      if (!reset) begin
         m_busy = 1'b0; m_rr = 1'b0; m_rid = 1'b0; m_k = 0;
         m_data = '0; m_rdata = '0; m_a = '0; m_b = '0;
         m_opc = '0; m_f7 = '0; m_f3 = '0; m_mux = '0;
      end
      e_rdy = 2'b00;
      if (reset && !m_busy && req_valid != 2'b00) e_rdy = pick(req_valid, m_rr) ? 2'b10 : 2'b01;
      check("model_req_ready", req_ready, e_rdy);
      check("model_resp_valid", resp_valid, m_busy && m_k >= W1);
      check("model_resp_data", resp_data, m_rdata);
      check("model_resp_id", resp_id, m_rid);
      check("model_alu_opcode", alu_opcode, m_opc);
      check("model_alu_funct3", alu_funct3, m_f3);
      check("model_alu_funct7", alu_funct7, m_f7);
      check("model_alu_rs1", alu_bus_rs1, m_a);
      check("model_alu_rs2", alu_bus_rs2, m_b);
      check("model_alu_imm", alu_immediate, m_b);
      check("model_alu_mux2", alu_mux2_select, m_mux);
      check("model_alu_consts", {alu_FLEN, alu_mux1_select, alu_Forward_rs1 | alu_Forward_rs2},
            32'd0);
      if (reset) begin
         if (!m_busy) begin
            if (req_valid != 2'b00) begin
               m_g = pick(req_valid, m_rr);
               m_gi = int'(m_g);
               m_opc = req_opcode[7*m_gi +: 7];
               m_f3 = req_funct3[3*m_gi +: 3];
               m_f7 = req_funct7[7*m_gi +: 7];
               m_a = req_operand_a[32*m_gi +: 32];
               m_b = req_operand_b[32*m_gi +: 32];
               m_mux = (m_opc == OPI) ? 2'b10 : 2'b00;
               m_data = alu_ref(m_opc, m_f3, m_f7, m_a, m_b);
               m_rid = m_g;
               m_rr = ~m_g;
               m_busy = 1'b1;
               m_k = 0;
            end
         end else if (m_k < W1) begin
            m_k++;
            if (m_k == W1) m_rdata = m_data;
         end else if (resp_ready) begin
            m_busy = 1'b0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      req_opcode[7*i +: 7]     = opc;
      req_funct3[3*i +: 3]     = f3;
      req_funct7[7*i +: 7]     = f7;
      req_operand_a[32*i +: 32] = a;
      req_operand_b[32*i +: 32] = b;
      req_valid[i]             = 1'b1;
   endtask

   // Call just after an accepting edge; returns edges from accept to resp_valid.
   task automatic wait_resp(input string name, output int lat);
      lat = -1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) fail_bound(name);
   endtask

   task automatic wait_grant(input string name, output logic g, output logic ok);
      ok = 1'b0;
      g  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            ok = 1'b1;
            g  = req_ready[1];
            break;
         end
      end
      if (!ok) fail_bound(name);
   endtask

   task automatic pulse_reset;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   int   lat;
   logic g, ok;

   initial begin
      req_valid = '0; req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
      req_operand_a = '0; req_operand_b = '0; resp_ready = 1'b1;
      v3 = '0; rr3 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_alu_opcode", alu_opcode, 7'd0);
      check("rst_req_ready", req_ready, 2'b00);
      reset = 1'b1;
      tick();

      // ADDI 1+3 from requester 0
      drive(0, OPI, 3'b000, 7'd0, 32'd1, 32'd3);
      @(negedge clk); check("t1_ready", req_ready, 2'b01);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      wait_resp("t1_wait", lat);
      check("t1_latency", lat, 1);
      check("t1_mux2", alu_mux2_select, 2'b10);
      check("t1_data", resp_data, 32'h00000004);
      check("t1_id", resp_id, 1'b0);
      tick();
      @(negedge clk); check("t1_idle", resp_valid, 1'b0);
      tick();

      // Simultaneous AND (req 0) and SRL (req 1) right after reset
      pulse_reset();
      drive(0, OPR, 3'b111, 7'd0, 32'h000100ff, 32'h0001ff00);
      drive(1, OPR, 3'b101, 7'd0, 32'h80000000, 32'h00000001);
      @(negedge clk); check("t2_ready0", req_ready, 2'b01);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      wait_resp("t2_wait0", lat);
      check("t2_data0", resp_data, 32'h00010000);
      check("t2_id0", resp_id, 1'b0);
      check("t2_ready_in_resp", req_ready, 2'b00);
      tick();
      @(negedge clk); check("t2_ready1", req_ready, 2'b10);
      @(posedge clk); #1 req_valid[1] = 1'b0;
      wait_resp("t2_wait1", lat);
      check("t2_data1", resp_data, 32'h40000000);
      check("t2_id1", resp_id, 1'b1);
      tick();

      // Both held valid for four operations: strict alternation
      drive(0, OPR, 3'b000, 7'd0, 32'd5, 32'd6);
      drive(1, OPR, 3'b000, 7'd0, 32'd7, 32'd8);
      for (int n = 0; n < 4; n++) begin
         wait_grant($sformatf("t3_grant_wait%0d", n), g, ok);
         if (ok) check($sformatf("t3_grant%0d", n), g, n % 2);
         @(posedge clk); #1;
         if (n == 3) req_valid = 2'b00;
      end
      wait_resp("t3_wait_last", lat);
      check("t3_last_data", resp_data, 32'd15);
      tick();

      // Response stall with requester 0 waiting
      resp_ready = 1'b0;
      drive(1, OPI, 3'b000, 7'd0, 32'd10, 32'd20);
      @(negedge clk); check("t4_ready", req_ready, 2'b10);
      @(posedge clk); #1 req_valid[1] = 1'b0;
      drive(0, OPI, 3'b000, 7'd0, 32'd2, 32'd2);
      wait_resp("t4_wait", lat);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("t4_stall_valid", resp_valid, 1'b1);
         check("t4_stall_data", resp_data, 32'd30);
         check("t4_stall_id", resp_id, 1'b1);
         check("t4_stall_ready", req_ready, 2'b00);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      @(negedge clk); check("t4_still_resp", resp_valid, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_exit_valid", resp_valid, 1'b0);
      check("t4_exit_ready", req_ready, 2'b01);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      wait_resp("t4_wait2", lat);
      check("t4_data2", resp_data, 32'd4);
      tick();

      // Asynchronous reset in the middle of ISSUE
      drive(0, OPI, 3'b000, 7'd0, 32'h11, 32'h22);
      @(negedge clk);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("t5_rst_valid", resp_valid, 1'b0);
      check("t5_rst_data", resp_data, 32'd0);
      check("t5_rst_opcode", alu_opcode, 7'd0);
      check("t5_rst_rs1", alu_bus_rs1, 32'd0);
      check("t5_rst_imm", alu_immediate, 32'd0);
      check("t5_rst_mux2", alu_mux2_select, 2'b00);
      @(posedge clk); #1 reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); check("t5_no_resp", resp_valid, 1'b0);
      end
      tick();
      drive(0, OPI, 3'b000, 7'd0, 32'd1, 32'd3);
      @(negedge clk); check("t5_ready", req_ready, 2'b01);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      wait_resp("t5_wait", lat);
      check("t5_latency", lat, 1);
      check("t5_data", resp_data, 32'd4);
      check("t5_id", resp_id, 1'b0);
      tick();

      // WAIT_CYCLES=3 instance: inputs held for 3 cycles, result after 3 edges
      drive(0, OPI, 3'b000, 7'd0, 32'd1, 32'd3);
      req_valid[0] = 1'b0;
      v3 = 2'b01;
      @(negedge clk); check("t6_ready", rdy3, 2'b01);
      @(posedge clk); #1 v3 = 2'b00;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("t6_valid_e%0d", c), rv3, c == 3);
         check("t6_opcode", a3_opcode, OPI);
         check("t6_rs1", a3_rs1, 32'd1);
         check("t6_rs2", a3_rs2, 32'd3);
         check("t6_mux2", a3_mux2, 2'b10);
      end
      check("t6_data", d3, 32'd4);
      check("t6_id", id3, 1'b0);
      tick();
      @(negedge clk); check("t6_idle", rv3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/alu_request_arbiter.md
Name: alu_request_arbiter

Overview:
- Shares the single combinational Arithmetic_Logic_Unit between two requesters: the execute stage (req 0) and the address-generation/auxiliary unit (req 1).
- Uses a per-requester valid/ready request handshake and a shared, ID-tagged valid/ready response channel.
- Registers the selected operation, drives the ALU input bus from those registers, waits a configurable number of cycles, then captures the result and holds it until the response is accepted.
- Sits between the pipeline control and the ALU instance, in place of direct ALU port wiring.

Parameters:
- WAIT_CYCLES, 1, cycles the ALU inputs are held stable before the result is captured. Legal range is 1 or more; 1 suits the single-cycle ALU, larger values suit multi-cycle variants.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: requester i's operation is accepted this cycle
- req_opcode  in  14  requester i opcode in [7i+6:7i]
- req_funct3  in  6  requester i funct3 in [3i+2:3i]
- req_funct7  in  14  requester i funct7 in [7i+6:7i]
- req_operand_a  in  64  requester i rs1 value in [32i+31:32i]
- req_operand_b  in  64  requester i rs2 value or immediate in [32i+31:32i]
- alu_opcode / alu_funct3 / alu_funct7  out  7/3/7  to ALU
- alu_FLEN  out  5  to ALU, constant 0
- alu_mux1_select  out  1  to ALU, constant 0
- alu_mux2_select  out  2  to ALU
- alu_bus_rs1, alu_bus_rs2, alu_immediate  out  32 each  to ALU
- alu_Forward_rs1, alu_Forward_rs2  out  32 each  to ALU, constant 0
- alu_result  in  32  ALU output
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  index of requester that owns resp_data
- resp_data  out  32  captured ALU result

Behaviour:
- States: IDLE, ISSUE, RESP.
- Reset (reset=0, asynchronous): state IDLE; all registered outputs 0, including every alu_* output, resp_valid, resp_id and resp_data; rr_ptr=0; counter 0. Any in-flight operation is discarded; no response is ever produced for it.
- IDLE, grant selection:
  - Only req 0 valid: grant 0. Only req 1 valid: grant 1.
  - Both valid: grant rr_ptr.
  - req_ready = one-hot of the grant, and is 0 when no request is valid. req_ready is combinational from req_valid and state.
- IDLE, accept (req_valid[g] and req_ready[g] at an edge):
  - Load opcode, funct3 and funct7 from requester g.
  - alu_bus_rs1 = operand_a. alu_bus_rs2 = alu_immediate = operand_b.
  - alu_mux2_select = 2'b10 if opcode is OP-IMM (0010011), else 2'b00.
  - resp_id = g; rr_ptr = ~g; counter = WAIT_CYCLES-1; go to ISSUE.
- ISSUE:
  - req_ready = 0; alu_* outputs stay stable.
  - At each edge: if counter==0, capture resp_data=alu_result, set resp_valid=1 and go to RESP; otherwise decrement the counter.
- Latency: resp_valid rises exactly WAIT_CYCLES edges after the accepting edge.
- RESP:
  - resp_valid=1; resp_data and resp_id stable; req_ready=0.
  - On the edge with resp_ready=1: resp_valid=0, go to IDLE.
  - resp_ready held low stalls indefinitely with no data change.
- Throughput: one operation per WAIT_CYCLES+2 cycles minimum; the RESP exit edge never accepts a new request.
- alu_* outputs keep their last issued values in RESP and IDLE until the next accept.
- Requester i must hold its req_* fields stable while req_valid[i]=1 and it has not yet been accepted.
- Counter width: $clog2(WAIT_CYCLES+1), minimum 1.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state encoding ST_IDLE, ST_ISSUE, ST_RESP
  - OPCODE_OP_IMM=7'b0010011 and OPCODE_OP=7'b0110011
  - MUX2_RS2=2'b00 and MUX2_IMM=2'b10
- Sub-module alu_rr_arbiter2: combinational 2-way round-robin grant from req_valid and rr_ptr. The rr_ptr register stays in the parent.

Test Plan:
- ADDI from req 0 (opcode 0010011, funct3 000, a=1, b=3), WAIT_CYCLES=1, resp_ready=1 -> alu_mux2_select=10; resp_valid 1 edge after accept; resp_data=00000004, resp_id=0.
- After reset, both valid on the same cycle: req 0 AND (0110011/111, a=000100ff, b=0001ff00) and req 1 SRL (0110011/101, a=80000000, b=1) -> req 0 served first with 00010000, id 0; then req 1 with 40000000, id 1.
- Both requesters held valid across 4 operations -> grant order 0,1,0,1; req_ready never has 2 bits set.
- resp_ready low for 5 cycles in RESP -> resp_valid, resp_data and resp_id unchanged; req_ready=00 throughout; IDLE on the first edge with resp_ready=1.
- reset pulled low mid-ISSUE, asynchronously between edges -> all outputs 0 immediately; no response is produced; after release, ADDI 1+3 completes normally.
- WAIT_CYCLES=3 build, ADDI 1+3 -> alu_* stable for 3 cycles; resp_valid rises exactly 3 edges after accept; resp_data=00000004.
